// File: rtl/register_writeback_queue.sv
// Register-file writeback queue: accepts load/ALU writebacks into an in-order buffer,
// drains one entry per cycle to the write port and forwards youngest pending values.
module register_writeback_queue #(
   parameter int unsigned REGISTER_SIZE = 31,
   parameter int unsigned ADDRESS_SIZE  = $clog2(REGISTER_SIZE + 1),
   parameter int unsigned QUEUE_DEPTH   = 4
) (
   input  logic                         system_clock,
   input  logic                         reset,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [ADDRESS_SIZE-1:0]      load_address,
   input  logic [REGISTER_SIZE:0]       load_data,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [ADDRESS_SIZE-1:0]      alu_address,
   input  logic [REGISTER_SIZE:0]       alu_data,
   input  logic                         write_stall,
   output logic                         write_enable,
   output logic [ADDRESS_SIZE-1:0]      write_address,
   output logic [REGISTER_SIZE:0]       write_data,
   input  logic [ADDRESS_SIZE-1:0]      read_address_1,
   input  logic [ADDRESS_SIZE-1:0]      read_address_2,
   output logic                         forward_hit_1,
   output logic                         forward_hit_2,
   output logic [REGISTER_SIZE:0]       forward_data_1,
   output logic [REGISTER_SIZE:0]       forward_data_2,
   output logic [$clog2(QUEUE_DEPTH):0] queue_count,
   output logic                         queue_empty
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

   logic [ADDRESS_SIZE-1:0] r_addr [QUEUE_DEPTH];
   logic [REGISTER_SIZE:0]  r_data [QUEUE_DEPTH];
   logic [PTR_W-1:0]        r_head;
   logic [PTR_W-1:0]        r_tail;
   logic [CNT_W-1:0]        r_count;

   logic                    w_empty;
   logic                    w_drain;
   logic                    w_space;
   logic                    w_load_fire;
   logic                    w_alu_fire;
   logic                    w_enq;
   logic [ADDRESS_SIZE-1:0] w_enq_addr;
   logic [REGISTER_SIZE:0]  w_enq_data;

   // Handshake and arbitration; a full queue still accepts when the head pops this cycle.
   assign w_empty     = (r_count == '0);
   assign w_drain     = !w_empty && !write_stall && !reset;
   assign w_space     = (r_count < FULL_COUNT) || w_drain;
   assign load_ready  = w_space;
   assign alu_ready   = w_space && !load_valid;
   assign w_load_fire = load_valid && load_ready;
   assign w_alu_fire  = alu_valid && alu_ready;
   assign w_enq_addr  = w_load_fire ? load_address : alu_address;
   assign w_enq_data  = w_load_fire ? load_data : alu_data;
   // Writes to register 0 are architecturally void, so they are accepted and dropped.
   assign w_enq       = (w_load_fire || w_alu_fire) && (w_enq_addr != '0);

   assign write_enable  = w_drain;
   assign write_address = r_addr[r_head];
   assign write_data    = r_data[r_head];
   assign queue_count   = r_count;
   assign queue_empty   = w_empty;

   // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_drain) r_head <= r_head + PTR_W'(1);
         if (w_enq)   r_tail <= r_tail + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_drain);
      end
   end

   // Entry payload storage; validity is carried entirely by the pointers and count.
   always_ff @(posedge system_clock) begin
      if (w_enq) begin
         r_addr[r_tail] <= w_enq_addr;
         r_data[r_tail] <= w_enq_data;
      end
   end

   // Scan oldest to youngest so the last match wins; the draining head is still visible.
   always_comb begin
      logic [PTR_W-1:0] w_idx;
      w_idx          = '0;
      forward_hit_1  = 1'b0;
      forward_hit_2  = 1'b0;
      forward_data_1 = '0;
      forward_data_2 = '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
         w_idx = r_head + PTR_W'(i);
         if (CNT_W'(i) < r_count) begin
            if ((r_addr[w_idx] == read_address_1) && (read_address_1 != '0)) begin
               forward_hit_1  = 1'b1;
               forward_data_1 = r_data[w_idx];
            end
            if ((r_addr[w_idx] == read_address_2) && (read_address_2 != '0)) begin
               forward_hit_2  = 1'b1;
               forward_data_2 = r_data[w_idx];
            end
         end
      end
   end

endmodule
